corr_dump_sequencer: RTL and testbench
======================================

CORR_DUMP_SEQUENCER -- requirements
Module: corr_dump_sequencer

Interface
REQ-001 SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- seen  in  32  CorrelationSeen vector; bit n is a dump pending on correlator n.
- enable_mask  in  32  bit n=1 lets correlator n be serviced.
- bus_gnt  in  1  shared register bus granted to this master.
- bus_req  out  1  bus request.
- addr  out  32  register address.
- read  out  1  read strobe.
- Rdata  in  32  read data, valid combinationally in the same cycle as read.
- out_valid  out  1  result record valid.
- out_ready  in  1  result consumer ready.
- out_id  out  5  correlator index.
- out_cnt  out  32  sample count at dump.
- out_corr  out  64  signed correlation value {High,Low}.
- threshold  in  32  unsigned magnitude threshold; used only with the REQ-017 macro.

Function
REQ-003 Correlator n register addresses SHALL be: Cnt 0xFE000740+16n, Low +4, High +8, Status +0xC.
REQ-004 The FSM SHALL have states IDLE, SEL, RD_CNT, RD_LOW, RD_HIGH, RD_STAT and EMIT.
REQ-005 IDLE: when (seen & enable_mask) is non-zero, SHALL go to SEL next cycle with bus_req=1.
REQ-006 SEL: SHALL choose the lowest pending index at or above last_id+1 (mod 32), wrapping round-robin, latch it into cur_id, and go to RD_CNT.
REQ-006a SEL: if the pending set is now empty, SHALL return to IDLE.
REQ-007 bus_req SHALL be 1 from SEL through RD_STAT inclusive, and 0 otherwise.
REQ-008 In each RD_* state with bus_gnt=1, read SHALL be 1 for exactly one cycle with the matching addr.
- Rdata SHALL be captured at the end of that cycle.
- The FSM SHALL advance in the order RD_CNT->RD_LOW->RD_HIGH->RD_STAT->EMIT.
REQ-009 In an RD_* state with bus_gnt=0, read SHALL be 0, addr SHALL hold, and the state SHALL hold; the read is retried when the grant returns.
REQ-010 The Status read SHALL always be last, because it clears the correlator's seen bit; Status data SHALL be discarded.
REQ-011 With bus_gnt held at 1, SEL to the first EMIT cycle SHALL take exactly 5 cycles.
REQ-012 EMIT: out_valid=1, with out_id/out_cnt/out_corr held stable until the cycle out_valid&out_ready=1.
- After that cycle: last_id<=cur_id, then go to SEL if further work is pending, else IDLE.
REQ-013 out_corr SHALL equal {High,Low} exactly as read, with no arithmetic applied.
REQ-014 Deasserting enable_mask bit n mid-sequence SHALL NOT abort correlator n's in-progress sequence; the mask affects only SEL.
REQ-015 A seen bit dropping mid-sequence SHALL NOT abort the sequence.
REQ-016 read and bus_req SHALL never be 1 in IDLE or EMIT.

Configuration
REQ-017 With CORR_DUMP_THRESH_EN defined:
- EMIT SHALL assert out_valid only if |out_corr| (two's-complement magnitude, 64-bit) >= zero-extended threshold.
- Otherwise EMIT SHALL silently complete in one cycle, as if handshaken.
- |-2^63| SHALL be treated as passing.
REQ-018 Without CORR_DUMP_THRESH_EN, threshold SHALL be ignored and every dump SHALL be emitted.

Reset
REQ-019 While rst=1 at a clk edge, the FSM SHALL go to IDLE with:
- bus_req=0, read=0, addr=0, out_valid=0;
- out_id=0, out_cnt=0, out_corr=0;
- cur_id=0 and last_id=31, so correlator 0 has first priority.
REQ-020 Reset mid-sequence SHALL abandon the sequence without a Status read; the seen bit remains set and that correlator is re-serviced afterwards.

Verification
REQ-021 Directed scenarios (stimulus -> required response):
- seen=0x00100000, mask=all ones, gnt=1; model returns Cnt=0x1234, Low=0xFFFFFFF0, High=0xFFFFFFFF -> read addrs 0xFE000880/884/888/88C on consecutive cycles; out_id=20, out_cnt=0x1234, out_corr=-16.
- seen=0x80000003 held, last_id=0 -> service order 1, 31, 0.
- gnt dropped for 3 cycles during RD_LOW of id 2 -> read=0 for those cycles, then the 0xFE000764 read; the record is correct.
- out_ready=0 for 10 cycles in EMIT -> outputs stable, no bus reads, single transfer afterwards.
- rst pulsed during RD_HIGH of id 5 -> IDLE, outputs 0; id 5 re-read fully starting at 0xFE000790.
- With CORR_DUMP_THRESH_EN, threshold=100: out_corr=-99 -> no out_valid; out_corr=-100 -> emitted.

Source files
------------

// File: rtl/corr_dump_sequencer.sv
// corr_dump_sequencer
// Services pending correlator dumps one at a time, in round-robin order.
// For each selected correlator it reads Cnt, Low, High and then Status over
// the shared register bus and presents {High,Low} with the count as a record.
// Status is always read last because that read clears the correlator's
// seen bit.
// Optional build macro CORR_DUMP_THRESH_EN: a record is presented only when
// |out_corr| >= threshold. Otherwise it is dropped silently. Without the
// macro, threshold is ignored.
module corr_dump_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seen,
  input  logic [31:0] enable_mask,
  input  logic        bus_gnt,
  output logic        bus_req,
  output logic [31:0] addr,
  output logic        read,
  input  logic [31:0] Rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_id,
  output logic [31:0] out_cnt,
  output logic [63:0] out_corr,
  input  logic [31:0] threshold
);

  localparam logic [31:0] CORR_BASE = 32'hFE000740;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEL     = 3'd1,
    RD_CNT  = 3'd2,
    RD_LOW  = 3'd3,
    RD_HIGH = 3'd4,
    RD_STAT = 3'd5,
    EMIT    = 3'd6
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cur_id_reg, last_id_reg;
  logic [31:0] out_cnt_reg;
  logic [63:0] out_corr_reg;

  logic [31:0] pending;
  logic        any_pending;
  logic [4:0]  start_id;
  logic [31:0] rot_pending;
  logic [4:0]  sel_off;
  logic [4:0]  sel_id;
  logic        is_rd_state;
  logic [31:0] rd_offset;
  logic        emit_pass;
  logic        emit_done;

  // The mask only gates selection; an in-progress sequence ignores it.
  assign pending     = seen & enable_mask;
  assign any_pending = |pending;
  assign start_id    = last_id_reg + 5'd1;

  // Rotate the pending set so that bit 0 is the correlator after the last one served.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rot
      assign rot_pending[gi] = pending[start_id + 5'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated set gives the round-robin winner.
  always_comb begin
    sel_off = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (rot_pending[i]) sel_off = 5'(i);
    end
  end

  assign sel_id = start_id + sel_off;

  // Magnitude test on the captured value; -2^63 negates to 2^63, which passes.
`ifdef CORR_DUMP_THRESH_EN
  logic [63:0] corr_mag;
  assign corr_mag  = out_corr_reg[63] ? (~out_corr_reg + 64'd1) : out_corr_reg;
  assign emit_pass = (corr_mag >= {32'd0, threshold});
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign emit_pass        = 1'b1;
`endif

  // A record leaves EMIT on handshake, or at once when it is filtered out.
  assign emit_done = (state_reg == EMIT) && (!emit_pass || out_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; bus read states only advance while the bus is granted.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_pending) state_next = SEL;
      SEL:     state_next = any_pending ? RD_CNT : IDLE;
      RD_CNT:  if (bus_gnt) state_next = RD_LOW;
      RD_LOW:  if (bus_gnt) state_next = RD_HIGH;
      RD_HIGH: if (bus_gnt) state_next = RD_STAT;
      RD_STAT: if (bus_gnt) state_next = EMIT;
      EMIT:    if (emit_done) state_next = any_pending ? SEL : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: bus request spans SEL..RD_STAT, reads only with grant.
  always_comb begin
    bus_req     = 1'b0;
    is_rd_state = 1'b0;
    rd_offset   = 32'd0;
    out_valid   = 1'b0;
    case (state_reg)
      SEL:     bus_req = 1'b1;
      RD_CNT:  begin bus_req = 1'b1; is_rd_state = 1'b1; rd_offset = 32'h0; end
      RD_LOW:  begin bus_req = 1'b1; is_rd_state = 1'b1; rd_offset = 32'h4; end
      RD_HIGH: begin bus_req = 1'b1; is_rd_state = 1'b1; rd_offset = 32'h8; end
      RD_STAT: begin bus_req = 1'b1; is_rd_state = 1'b1; rd_offset = 32'hC; end
      EMIT:    out_valid = emit_pass;
      default: ;
    endcase
    read = is_rd_state && bus_gnt;
    addr = is_rd_state ? (CORR_BASE + {23'd0, cur_id_reg, 4'd0} + rd_offset) : 32'd0;
  end

  // Datapath: latch the winner, capture read data, remember the last served id.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id_reg   <= 5'd0;
      last_id_reg  <= 5'd31;
      out_cnt_reg  <= 32'd0;
      out_corr_reg <= 64'd0;
    end else begin
      if (state_reg == SEL && any_pending) cur_id_reg <= sel_id;
      if (read && state_reg == RD_CNT)  out_cnt_reg         <= Rdata;
      if (read && state_reg == RD_LOW)  out_corr_reg[31:0]  <= Rdata;
      if (read && state_reg == RD_HIGH) out_corr_reg[63:32] <= Rdata;
      if (emit_done) last_id_reg <= cur_id_reg;
    end
  end

  assign out_id   = cur_id_reg;
  assign out_cnt  = out_cnt_reg;
  assign out_corr = out_corr_reg;

endmodule

// File: tb/tb_corr_dump_sequencer.sv
// Directed testbench for corr_dump_sequencer. A small correlator register
// bank answers reads combinationally; the bench drops seen bits itself.
module tb_corr_dump_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seen;
  logic [31:0] enable_mask;
  logic        bus_gnt;
  logic        bus_req;
  logic [31:0] addr;
  logic        read;
  logic [31:0] Rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_id;
  logic [31:0] out_cnt;
  logic [63:0] out_corr;
  logic [31:0] threshold;

  int tests  = 0;
  int failed = 0;

  logic [31:0] cnt_mem  [32];
  logic [31:0] low_mem  [32];
  logic [31:0] high_mem [32];
  logic [31:0] rel;

  always #5 clk = ~clk;

  corr_dump_sequencer dut (
    .clk(clk), .rst(rst), .seen(seen), .enable_mask(enable_mask),
    .bus_gnt(bus_gnt), .bus_req(bus_req), .addr(addr), .read(read),
    .Rdata(Rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_cnt(out_cnt), .out_corr(out_corr),
    .threshold(threshold)
  );

  // Register bank model: Cnt/Low/High per correlator, Status returns a marker.
  always_comb begin
    rel   = addr - 32'hFE000740;
    Rdata = 32'hDEADBEEF;
    if (rel < 32'd512) begin
      case (rel[3:0])
        4'h0:    Rdata = cnt_mem[rel[8:4]];
        4'h4:    Rdata = low_mem[rel[8:4]];
        4'h8:    Rdata = high_mem[rel[8:4]];
        default: Rdata = 32'h5A5A0000;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance negedges until read is seen (bounded); n returns cycles waited.
  task automatic wait_read(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!read && n < 20);
    chk({tag, "_read_seen"}, 64'(read), 64'd1);
  endtask

  // Full service of one correlator with grant held; clr_at: 0 keep seen,
  // 1 drop seen right after Cnt, 4 drop after Status. Ends at the EMIT negedge.
  task automatic service(input int id, input bit emit_exp, input int clr_at, input bit mask_drop);
    int n;
    logic [31:0] base;
    string t;
    t    = $sformatf("id%0d", id);
    base = 32'hFE000740 + 32'(16 * id);
    wait_read(t, n);
    chk({t, "_latency"}, 64'(n), 64'd2);
    chk({t, "_bus_req"}, 64'(bus_req), 64'd1);
    chk({t, "_addr_cnt"}, 64'(addr), 64'(base));
    if (mask_drop) enable_mask[id] = 1'b0;
    if (clr_at == 1) seen[id] = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk({t, "_read"}, 64'(read), 64'd1);
      chk({t, "_addr"}, 64'(addr), 64'(base + 32'(4 * k)));
    end
    if (clr_at == 4) seen[id] = 1'b0;
    @(negedge clk);
    chk({t, "_emit_read"}, 64'(read), 64'd0);
    chk({t, "_emit_bus_req"}, 64'(bus_req), 64'd0);
    chk({t, "_out_valid"}, 64'(out_valid), 64'(emit_exp));
    if (emit_exp) begin
      chk({t, "_out_id"}, 64'(out_id), 64'(id));
      chk({t, "_out_cnt"}, 64'(out_cnt), 64'(cnt_mem[id]));
      chk({t, "_out_corr"}, out_corr, {high_mem[id], low_mem[id]});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      cnt_mem[i]  = 32'h1000 + 32'(i);
      low_mem[i]  = 32'h0111 * 32'(i + 1);
      high_mem[i] = 32'(i);
    end
    cnt_mem[20] = 32'h1234; low_mem[20] = 32'hFFFFFFF0; high_mem[20] = 32'hFFFFFFFF;
    low_mem[9]  = 32'hFFFFFF9D; high_mem[9]  = 32'hFFFFFFFF;  // -99
    low_mem[10] = 32'hFFFFFF9C; high_mem[10] = 32'hFFFFFFFF;  // -100
    low_mem[11] = 32'h00000000; high_mem[11] = 32'h80000000;  // -2^63

    rst = 1'b1; seen = 32'd0; enable_mask = 32'hFFFFFFFF;
    bus_gnt = 1'b1; out_ready = 1'b1; threshold = 32'd100;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_read", 64'(read), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    chk("rst_out_corr", out_corr, 64'd0);
    rst = 1'b0;

    // Single dump on correlator 20, negative correlation
    seen = 32'h00100000;
    service(20, 1'b1, 4, 1'b0);
    chk("s1_corr_minus16", out_corr, 64'hFFFFFFFFFFFFFFF0);
    @(negedge clk);
    chk("s1_idle_valid", 64'(out_valid), 64'd0);
    chk("s1_idle_bus_req", 64'(bus_req), 64'd0);

    // Round-robin: serve 0 to set last_id=0, then 1, 31, 0 with seen held
    seen = 32'h00000001;
    service(0, 1'b1, 4, 1'b0);
    seen = 32'h80000003;
    service(1, 1'b1, 0, 1'b0);
    service(31, 1'b1, 0, 1'b0);
    service(0, 1'b1, 0, 1'b0);
    seen = 32'd0;
    @(negedge clk);
    chk("s2_idle_bus_req", 64'(bus_req), 64'd0);

    // Grant dropped for 3 cycles while in RD_LOW of id 2
    begin
      int n;
      seen = 32'h00000004;
      wait_read("s3", n);
      chk("s3_addr_cnt", 64'(addr), 64'hFE000760);
      @(posedge clk); #1 bus_gnt = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("s3_nogrant_read", 64'(read), 64'd0);
        chk("s3_nogrant_addr", 64'(addr), 64'hFE000764);
        chk("s3_nogrant_bus_req", 64'(bus_req), 64'd1);
      end
      @(posedge clk); #1 bus_gnt = 1'b1;
      @(negedge clk);
      chk("s3_retry_read", 64'(read), 64'd1);
      chk("s3_retry_addr", 64'(addr), 64'hFE000764);
      @(negedge clk);
      chk("s3_addr_high", 64'(addr), 64'hFE000768);
      @(negedge clk);
      chk("s3_addr_stat", 64'(addr), 64'hFE00076C);
      seen = 32'd0;
      @(negedge clk);
      chk("s3_out_valid", 64'(out_valid), 64'd1);
      chk("s3_out_id", 64'(out_id), 64'd2);
      chk("s3_out_cnt", 64'(out_cnt), 64'h1002);
      chk("s3_out_corr", out_corr, {32'd2, 32'h0333});
    end

    // Back-pressure: out_ready low for 10 EMIT cycles on id 7
    @(negedge clk);
    out_ready = 1'b0;
    seen = 32'h00000080;
    service(7, 1'b1, 4, 1'b0);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk("s4_hold_valid", 64'(out_valid), 64'd1);
      chk("s4_hold_id", 64'(out_id), 64'd7);
      chk("s4_hold_corr", out_corr, {32'd7, 32'h0888});
      chk("s4_hold_read", 64'(read), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("s4_single_xfer", 64'(out_valid), 64'd0);

    // Reset during RD_HIGH of id 5, then full re-service
    begin
      int n;
      seen = 32'h00000020;
      wait_read("s5", n);
      chk("s5_addr_cnt", 64'(addr), 64'hFE000790);
      @(negedge clk);
      chk("s5_addr_low", 64'(addr), 64'hFE000794);
      @(negedge clk);
      chk("s5_addr_high", 64'(addr), 64'hFE000798);
      rst = 1'b1;
      @(negedge clk);
      chk("s5_rst_bus_req", 64'(bus_req), 64'd0);
      chk("s5_rst_read", 64'(read), 64'd0);
      chk("s5_rst_addr", 64'(addr), 64'd0);
      chk("s5_rst_out_id", 64'(out_id), 64'd0);
      chk("s5_rst_out_cnt", 64'(out_cnt), 64'd0);
      chk("s5_rst_out_corr", out_corr, 64'd0);
      rst = 1'b0;
      service(5, 1'b1, 4, 1'b0);
    end

    // Threshold behaviour (ignored in the default build)
    @(negedge clk);
    seen = 32'h00000200;
`ifdef CORR_DUMP_THRESH_EN
    service(9, 1'b0, 4, 1'b0);
`else
    service(9, 1'b1, 4, 1'b0);
`endif
    @(negedge clk);
    chk("s6_after9_valid", 64'(out_valid), 64'd0);
    chk("s6_after9_bus_req", 64'(bus_req), 64'd0);
    // -100 passes; its mask bit and seen bit drop mid-sequence
    seen = 32'h00000400;
    service(10, 1'b1, 1, 1'b1);
    enable_mask = 32'hFFFFFFFF;
    @(negedge clk);
    seen = 32'h00000800;
    service(11, 1'b1, 4, 1'b0);
    @(negedge clk);

    // A masked pending correlator is never serviced
    seen = 32'h00001000;
    enable_mask = 32'hFFFFEFFF;
    repeat (5) begin
      @(negedge clk);
      chk("s7_masked_bus_req", 64'(bus_req), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
